// File: rtl/stopwatch_ctrl_if.sv
// Button and counter-side signal bundle for the stopwatch controller.
// The slave modport is the controller; the master modport is the board/counter side.
interface stopwatch_ctrl_if #(
    parameter int unsigned CNT_W = 20
);
    logic             start_n;
    logic             stop_n;
    logic             lap_n;
    logic             clear_n;
    logic [CNT_W-1:0] ms_count;
    logic             cnt_en;
    logic             cnt_clr;
    logic [CNT_W-1:0] lap_value;
    logic             lap_valid;
    logic             running;
    logic             overflow;

    modport master (
        output start_n, stop_n, lap_n, clear_n, ms_count,
        input  cnt_en, cnt_clr, lap_value, lap_valid, running, overflow
    );

    modport slave (
        input  start_n, stop_n, lap_n, clear_n, ms_count,
        output cnt_en, cnt_clr, lap_value, lap_valid, running, overflow
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button conditioning (sync, debounce, press detect), 1 ms prescaler,
// and the IDLE/RUNNING/LAP/PAUSED controller driving the external ms counter.
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 1000,
    parameter int unsigned DEB_CYCLES = 500_000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic            clk,
    input  logic            reset_n,
    stopwatch_ctrl_if.slave sw
);
    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned PW    = $clog2(DIV);
    localparam int unsigned DW    = $clog2(DEB_CYCLES + 1);
    localparam int unsigned NB    = 4;
    localparam int unsigned B_LAP = 0;
    localparam int unsigned B_STA = 1;
    localparam int unsigned B_STO = 2;
    localparam int unsigned B_CLR = 3;

    typedef enum logic [1:0] {IDLE, RUNNING, LAP, PAUSED} state_t;

    logic [NB-1:0] raw_n;
    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] deb_q, deb_d;
    logic [NB-1:0] ev_q, ev_d;
    logic [DW-1:0] deb_cnt_q [NB];
    logic [DW-1:0] deb_cnt_d [NB];

    assign raw_n = {sw.clear_n, sw.stop_n, sw.start_n, sw.lap_n};

    // Level flips only after DEB_CYCLES consecutive disagreeing samples; any agreement restarts.
    always_comb begin
        deb_d = deb_q;
        for (int unsigned i = 0; i < NB; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
        ev_d = deb_q & ~deb_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            ev_q    <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            ev_q    <= ev_d;
            for (int unsigned i = 0; i < NB; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] lap_value_q, lap_value_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             lap_valid_q, lap_valid_d;
    logic             running_q, running_d;
    logic             overflow_q, overflow_d;
    logic             counting, tick, at_max;

    always_comb begin
        counting    = (state_q == RUNNING) || (state_q == LAP);
        tick        = counting && (presc_q == PW'(DIV - 1));
        at_max      = (sw.ms_count == '1);
        state_d     = state_q;
        lap_value_d = lap_value_q;
        overflow_d  = overflow_q;
        cnt_clr_d   = 1'b0;
        cnt_en_d    = tick && !at_max;

        if (state_q == IDLE) begin
            presc_d = '0;
        end else if (!counting) begin
            presc_d = presc_q;
        end else if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // Each state tests only the events it reacts to, highest priority first.
        case (state_q)
            IDLE: begin
                if (ev_q[B_CLR]) begin
                    cnt_clr_d = 1'b1;
                end else if (ev_q[B_STA]) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                if (ev_q[B_STO]) begin
                    state_d = PAUSED;
                end else if (ev_q[B_LAP]) begin
                    state_d     = LAP;
                    lap_value_d = sw.ms_count;
                end
            end
            LAP: begin
                if (ev_q[B_STO]) begin
                    state_d = PAUSED;
                end else if (ev_q[B_STA]) begin
                    state_d = RUNNING;
                end else if (ev_q[B_LAP]) begin
                    lap_value_d = sw.ms_count;
                end
            end
            default: begin
                if (ev_q[B_CLR]) begin
                    state_d     = IDLE;
                    cnt_clr_d   = 1'b1;
                    lap_value_d = '0;
                    overflow_d  = 1'b0;
                    presc_d     = '0;
                end else if (ev_q[B_STA] && !overflow_q) begin
                    state_d = RUNNING;
                end
            end
        endcase

        if (tick && at_max) begin
            overflow_d = 1'b1;
            state_d    = PAUSED;
        end

        lap_valid_d = (state_d == LAP);
        running_d   = (state_d == RUNNING) || (state_d == LAP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            lap_value_q <= '0;
            cnt_en_q    <= 1'b0;
            cnt_clr_q   <= 1'b0;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            lap_value_q <= lap_value_d;
            cnt_en_q    <= cnt_en_d;
            cnt_clr_q   <= cnt_clr_d;
            lap_valid_q <= lap_valid_d;
            running_q   <= running_d;
            overflow_q  <= overflow_d;
        end
    end

    assign sw.cnt_en    = cnt_en_q;
    assign sw.cnt_clr   = cnt_clr_q;
    assign sw.lap_value = lap_value_q;
    assign sw.lap_valid = lap_valid_q;
    assign sw.running   = running_q;
    assign sw.overflow  = overflow_q;
endmodule
